ofdm_rx_symbol_sequencer: RTL and testbench

Timing controller for the OFDM RX chain. Consumes the strobed input-sample valid and the coarse-alignment detector's hit, then skips the alignment offset and each cyclic prefix. It gates exactly symbol_length_g useful samples per symbol into the FFT and counts symbols per frame. It sits between the input sample interface and the FFT/demapper datapath, and is re-armed by sys_init.

---
 rtl/ofdm_rx_seq_pkg.sv | 24 ++
 rtl/ofdm_rx_strobe_counter.sv | 37 +++
 rtl/ofdm_rx_symbol_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_ofdm_rx_symbol_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_rx_seq_pkg.sv
// Shared types and sizing helpers for the OFDM RX symbol sequencer.
package ofdm_rx_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_GUARD  = 3'd3,
    ST_DATA   = 3'd4
  } seq_state_e;

  localparam int FRAME_CNT_W   = 16;
  localparam int OVERRUN_CNT_W = 8;

  // Width needed to hold the largest length loaded into the strobe counter.
  function automatic int cnt_width(input int guard_len, input int sym_len, input int offset_w);
    int m;
    m = guard_len;
    if (sym_len > m) m = sym_len;
    if ((1 << offset_w) > m) m = 1 << offset_w;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ofdm_rx_strobe_counter.sv
// Loadable down-counter that decrements once per sample strobe; tc_o marks
// the strobe that consumes the final remaining count.
module ofdm_rx_strobe_counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == WIDTH'(1));

endmodule

// File: rtl/ofdm_rx_symbol_sequencer.sv
// OFDM RX timing controller: skips alignment offset and cyclic prefixes, gates
// useful samples into the FFT. Optional statistics via OFDM_RX_SEQUENCER_STATS_EN.
module ofdm_rx_symbol_sequencer
  import ofdm_rx_seq_pkg::*;
#(
  parameter int symbol_length_g     = 64,
  parameter int guard_length_g      = 16,
  parameter int symbols_per_frame_g = 12,
  parameter int offset_width_g      = 5
) (
  input  logic                               sys_clk,
  input  logic                               sys_rstn,
  input  logic                               sys_init_i,
  input  logic                               rx_data_valid_i,
  input  logic                               coarse_found_i,
  input  logic [offset_width_g-1:0]          coarse_offset_i,
  input  logic                               fft_busy_i,
  output logic                               sym_valid_o,
  output logic [$clog2(symbol_length_g)-1:0] sym_idx_o,
  output logic                               sym_start_o,
  output logic                               sym_end_o,
  output logic                               frame_done_o,
  output logic                               overrun_o,
  output logic [2:0]                         state_o
`ifdef OFDM_RX_SEQUENCER_STATS_EN
  ,
  output logic [FRAME_CNT_W-1:0]             frame_cnt_o,
  output logic [OVERRUN_CNT_W-1:0]           overrun_cnt_o
`endif
);

  localparam int IDX_W  = $clog2(symbol_length_g);
  localparam int CNT_W  = cnt_width(guard_length_g, symbol_length_g, offset_width_g);
  localparam int SCNT_W = $clog2(symbols_per_frame_g) + 1;
  localparam logic [CNT_W-1:0]  SYM_LEN_C   = CNT_W'(symbol_length_g);
  localparam logic [CNT_W-1:0]  GUARD_LEN_C = CNT_W'(guard_length_g);
  localparam logic [SCNT_W-1:0] LAST_SYM_C  = SCNT_W'(symbols_per_frame_g - 1);

  seq_state_e        state_q, state_d;
  logic [SCNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic              overrun_q, overrun_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              start_q, start_d;
  logic              end_q, end_d;
  logic              done_q, done_d;

  logic              cnt_load, cnt_dec, cnt_tc;
  logic [CNT_W-1:0]  cnt_load_val, cnt_value;
  logic              first_data_strobe;

  ofdm_rx_strobe_counter #(.WIDTH(CNT_W)) u_strobe_cnt (
    .clk        (sys_clk),
    .rst_n      (sys_rstn),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .count_o    (cnt_value),
    .tc_o       (cnt_tc)
  );

  // A full count in DATA means no sample of this symbol has been gated yet.
  assign first_data_strobe = (state_q == ST_DATA) && rx_data_valid_i && !sys_init_i &&
                             (cnt_value == SYM_LEN_C);

  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    overrun_d    = overrun_q;
    valid_d      = 1'b0;
    idx_d        = idx_q;
    start_d      = 1'b0;
    end_d        = 1'b0;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    if (sys_init_i) begin
      state_d   = ST_SEARCH;
      sym_cnt_d = '0;
      overrun_d = 1'b0;
      idx_d     = '0;
      cnt_load  = 1'b1;
    end else if (rx_data_valid_i) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (coarse_found_i) begin
            cnt_load = 1'b1;
            if (coarse_offset_i == '0) begin
              state_d      = ST_GUARD;
              cnt_load_val = GUARD_LEN_C;
            end else begin
              state_d      = ST_ALIGN;
              cnt_load_val = CNT_W'(coarse_offset_i);
            end
          end
        end
        ST_ALIGN, ST_GUARD: begin
          if (cnt_tc) begin
            state_d      = (state_q == ST_ALIGN) ? ST_GUARD : ST_DATA;
            cnt_load     = 1'b1;
            cnt_load_val = (state_q == ST_ALIGN) ? GUARD_LEN_C : SYM_LEN_C;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_DATA: begin
          if (first_data_strobe && fft_busy_i) begin
            state_d   = ST_SEARCH;
            overrun_d = 1'b1;
            sym_cnt_d = '0;
            cnt_load  = 1'b1;
          end else begin
            valid_d = 1'b1;
            idx_d   = IDX_W'(SYM_LEN_C - cnt_value);
            start_d = first_data_strobe;
            if (cnt_tc) begin
              end_d    = 1'b1;
              cnt_load = 1'b1;
              if (sym_cnt_q == LAST_SYM_C) begin
                done_d    = 1'b1;
                sym_cnt_d = '0;
                state_d   = ST_SEARCH;
              end else begin
                sym_cnt_d    = sym_cnt_q + SCNT_W'(1);
                state_d      = ST_GUARD;
                cnt_load_val = GUARD_LEN_C;
              end
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q   <= ST_IDLE;
      sym_cnt_q <= '0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      start_q   <= start_d;
      end_q     <= end_d;
      done_q    <= done_d;
    end
  end

  assign sym_valid_o  = valid_q;
  assign sym_idx_o    = idx_q;
  assign sym_start_o  = start_q;
  assign sym_end_o    = end_q;
  assign frame_done_o = done_q;
  assign overrun_o    = overrun_q;
  assign state_o      = state_q;

`ifdef OFDM_RX_SEQUENCER_STATS_EN
  logic [FRAME_CNT_W-1:0]   frame_cnt_q;
  logic [OVERRUN_CNT_W-1:0] overrun_cnt_q;

  // Statistics survive sys_init_i; only the hardware reset clears them.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      frame_cnt_q   <= '0;
      overrun_cnt_q <= '0;
    end else begin
      if (done_d && (frame_cnt_q != '1)) begin
        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      end
      if (first_data_strobe && fft_busy_i && (overrun_cnt_q != '1)) begin
        overrun_cnt_q <= overrun_cnt_q + OVERRUN_CNT_W'(1);
      end
    end
  end

  assign frame_cnt_o   = frame_cnt_q;
  assign overrun_cnt_o = overrun_cnt_q;
`endif

endmodule

// File: tb/tb_ofdm_rx_symbol_sequencer.sv
// Scoreboard bench for ofdm_rx_symbol_sequencer; stats checks when OFDM_RX_SEQUENCER_STATS_EN is set.
module tb_ofdm_rx_symbol_sequencer;

  localparam int SYM = 64;
  localparam int GRD = 16;
  localparam int SPF = 12;
  localparam int PER = SYM + GRD;

  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
    logic       start;
    logic       fin;
    logic       done;
    logic       ovr;
    logic [2:0] st;
  } out_t;

  logic       sys_clk = 1'b0;
  logic       sys_rstn = 1'b0;
  logic       sys_init_i = 1'b0;
  logic       rx_data_valid_i = 1'b0;
  logic       coarse_found_i = 1'b0;
  logic [4:0] coarse_offset_i = '0;
  logic       fft_busy_i = 1'b0;
  logic       sym_valid_o;
  logic [5:0] sym_idx_o;
  logic       sym_start_o;
  logic       sym_end_o;
  logic       frame_done_o;
  logic       overrun_o;
  logic [2:0] state_o;
`ifdef OFDM_RX_SEQUENCER_STATS_EN
  logic [15:0] frame_cnt_o;
  logic [7:0]  overrun_cnt_o;
`endif

  ofdm_rx_symbol_sequencer dut (
    .sys_clk         (sys_clk),
    .sys_rstn        (sys_rstn),
    .sys_init_i      (sys_init_i),
    .rx_data_valid_i (rx_data_valid_i),
    .coarse_found_i  (coarse_found_i),
    .coarse_offset_i (coarse_offset_i),
    .fft_busy_i      (fft_busy_i),
    .sym_valid_o     (sym_valid_o),
    .sym_idx_o       (sym_idx_o),
    .sym_start_o     (sym_start_o),
    .sym_end_o       (sym_end_o),
    .frame_done_o    (frame_done_o),
    .overrun_o       (overrun_o),
    .state_o         (state_o)
`ifdef OFDM_RX_SEQUENCER_STATS_EN
    ,
    .frame_cnt_o     (frame_cnt_o),
    .overrun_cnt_o   (overrun_cnt_o)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  out_t exp_q[$];
  out_t obs_q[$];

  // Positional reference: mode 0 idle, 1 searching, 2 locked on a hit.
  int m_mode = 0;
  int m_off  = 0;
  int m_j    = 0;
  bit m_ovr  = 1'b0;
  int m_frames = 0;
  int m_novr   = 0;

  function automatic logic [2:0] model_state();
    int pn;
    if (m_mode == 0) return 3'd0;
    if (m_mode == 1) return 3'd1;
    pn = m_j + 1 - m_off;
    if (pn <= 0) return 3'd2;
    return (((pn - 1) % PER) < GRD) ? 3'd3 : 3'd4;
  endfunction

  task automatic drive(input bit init, input bit v, input bit f, input int off, input bit busy);
    out_t e;
    out_t o;
    int   p, q, s, idx;
    sys_init_i      = init;
    rx_data_valid_i = v;
    coarse_found_i  = f;
    coarse_offset_i = 5'(off);
    fft_busy_i      = busy;
    e = '0;
    if (init) begin
      m_mode = 1;
      m_ovr  = 1'b0;
    end else if (v && (m_mode == 1) && f) begin
      m_mode = 2;
      m_off  = off;
      m_j    = 0;
    end else if (v && (m_mode == 2)) begin
      m_j++;
      p = m_j - m_off;
      if (p > 0) begin
        q = (p - 1) % PER;
        s = (p - 1) / PER;
        if (q >= GRD) begin
          idx = q - GRD;
          if ((idx == 0) && busy) begin
            m_ovr  = 1'b1;
            m_mode = 1;
            m_novr++;
          end else begin
            e.valid = 1'b1;
            e.idx   = 6'(idx);
            e.start = (idx == 0);
            e.fin   = (idx == SYM - 1);
            if ((idx == SYM - 1) && (s == SPF - 1)) begin
              e.done = 1'b1;
              m_mode = 1;
              m_frames++;
            end
          end
        end
      end
    end
    e.ovr = m_ovr;
    e.st  = model_state();
    exp_q.push_back(e);
    @(posedge sys_clk);
    @(negedge sys_clk);
    o.valid = sym_valid_o;
    o.idx   = sym_valid_o ? sym_idx_o : 6'd0;
    o.start = sym_start_o;
    o.fin   = sym_end_o;
    o.done  = frame_done_o;
    o.ovr   = overrun_o;
    o.st    = state_o;
    obs_q.push_back(o);
    sys_init_i = 1'b0; rx_data_valid_i = 1'b0; coarse_found_i = 1'b0; fft_busy_i = 1'b0;
  endtask

  task automatic strobes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, 0, 0, 0);
      for (int k = 1; k < gap; k++) drive(0, 0, 0, 0, 0);
    end
  endtask

  task automatic hit(input int off);
    drive(0, 1, 1, off, 0);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    out_t e, o;
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0);
    sys_rstn = 1'b1;
    strobes(3, 25);
    drive(0, 1, 1, 3, 0);
    strobes(2, 25);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset: got %h required %h", o, e);
      end
    end
    $display("[TB] reset/idle done");
  endtask

  task automatic test_nominal();
    out_t e, o;
    int nvalid = 0, ndone = 0;
    drive(1, 0, 0, 0, 0);
    strobes(4, 2);
    hit(3);
    strobes(3 + SPF * PER, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o.valid) nvalid++;
      if (o.done) ndone++;
      if (o !== e) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL nominal: got %h required %h", o, e);
      end
      if (e.fin) $display("[TB] nominal symbol end, frame_done=%0b", o.done);
    end
    n_tests++;
    if (nvalid !== SPF * SYM || ndone !== 1) begin
      n_fail++;
      $display("FAIL nominal_totals: got valid=%0d done=%0d required valid=%0d done=1", nvalid, ndone, SPF * SYM);
    end
  endtask

  task automatic test_offset0();
    out_t e, o;
    drive(1, 0, 0, 0, 0);
    hit(0);
    strobes(GRD + SYM + 3, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL offset0: got %h required %h", o, e);
      end
      if (e.start) $display("[TB] offset0 symbol start idx=%0d", o.idx);
    end
  endtask

  task automatic test_overrun();
    out_t e, o;
    drive(1, 0, 0, 0, 0);
    hit(2);
    strobes(2 + GRD + 5, 2);
    drive(0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    strobes(SYM - 6 + GRD, 2);
    drive(0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    strobes(4, 2);
    hit(1);
    strobes(5, 2);
    drive(1, 0, 0, 0, 0);
    strobes(2, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL overrun: got %h required %h", o, e);
      end
      if (e.fin) $display("[TB] overrun-test symbol end");
    end
    $display("[TB] overrun events so far %0d", m_novr);
  endtask

  task automatic test_mid_init();
    out_t e, o;
    drive(1, 0, 0, 0, 0);
    hit(1);
    strobes(1 + GRD + 30, 2);
    drive(1, 1, 1, 7, 0);
    drive(0, 0, 0, 0, 0);
    strobes(3, 2);
    hit(0);
    strobes(GRD + SYM + 2, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL mid_init: got %h required %h", o, e);
      end
      if (e.fin) $display("[TB] mid-init restart symbol end");
    end
  endtask

`ifdef OFDM_RX_SEQUENCER_STATS_EN
  task automatic test_stats();
    out_t e, o;
    drive(1, 0, 0, 0, 0);
    hit(4);
    strobes(4 + SPF * PER, 2);
    drive(1, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL stats_frame: got %h required %h", o, e);
      end
    end
    n_tests++;
    if (frame_cnt_o !== 16'(m_frames) || overrun_cnt_o !== 8'(m_novr) || m_frames != 2 || m_novr != 1) begin
      n_fail++;
      $display("FAIL stats: got frames=%0d overruns=%0d required frames=%0d overruns=%0d",
               frame_cnt_o, overrun_cnt_o, m_frames, m_novr);
    end
    $display("[TB] stats frames=%0d overruns=%0d", frame_cnt_o, overrun_cnt_o);
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_offset0();
    test_overrun();
    test_mid_init();
`ifdef OFDM_RX_SEQUENCER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
